// File: rtl/asmd_mult_arbiter_if.sv
// Bundle between the requester clients, the round-robin arbiter and the shared
// shift-add multiplier. The arbiter is master; clients/multiplier form the slave side.
interface asmd_mult_arbiter_if #(
  parameter int word_length = 8,
  parameter int num_req     = 4
);
  logic [num_req-1:0]             req;
  logic [num_req*word_length-1:0] req_a;
  logic [num_req*word_length-1:0] req_b;
  logic [num_req-1:0]             grant;
  logic [num_req-1:0]             done;
  logic [2*word_length-1:0]       result;
  logic                           busy;
  logic [word_length-1:0]         mul_word0;
  logic [word_length-1:0]         mul_word1;
  logic                           mul_start;
  logic [2*word_length-1:0]       mul_product;
  logic                           mul_ready;

  modport master (
    input  req, req_a, req_b, mul_product, mul_ready,
    output grant, done, result, busy, mul_word0, mul_word1, mul_start
  );

  modport slave (
    output req, req_a, req_b, mul_product, mul_ready,
    input  grant, done, result, busy, mul_word0, mul_word1, mul_start
  );
endinterface

// File: rtl/asmd_mult_arbiter.sv
// Round-robin scheduler sharing one asmd_multiplier among num_req requesters.
// Captures the winner's operands, pulses start, waits for the ready handshake, returns the product.
module asmd_mult_arbiter #(
  parameter int word_length = 8,
  parameter int num_req     = 4
) (
  input logic                 clk,
  input logic                 reset,
  asmd_mult_arbiter_if.master bus
);
  localparam int idx_w = $clog2(num_req);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_ACK  = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam logic [idx_w-1:0] last_idx = idx_w'(num_req - 1);

  logic [2:0]               state_r;
  logic [idx_w-1:0]         ptr_r;
  logic [idx_w-1:0]         owner_r;
  logic [num_req-1:0]       grant_r;
  logic [num_req-1:0]       done_r;
  logic [2*word_length-1:0] result_r;
  logic                     busy_r;
  logic                     mul_start_r;
  logic [word_length-1:0]   word0_r;
  logic [word_length-1:0]   word1_r;

  logic [idx_w-1:0]         winner_s;
  logic                     found_s;
  logic [idx_w-1:0]         cand_s;
  logic [word_length-1:0]   sel_a_s;
  logic [word_length-1:0]   sel_b_s;

  function automatic logic [idx_w-1:0] next_idx(input logic [idx_w-1:0] idx);
    logic [idx_w-1:0] nxt;
    if (idx == last_idx) begin
      nxt = {idx_w{1'b0}};
    end else begin
      nxt = idx + idx_w'(1);
    end
    return nxt;
  endfunction

  function automatic logic [num_req-1:0] onehot(input logic [idx_w-1:0] idx);
    logic [num_req-1:0] one;
    one = {{(num_req-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  // Round-robin search from ptr upward with wrap, plus operand mux for the winner
  always_comb begin
    winner_s = ptr_r;
    found_s  = 1'b0;
    cand_s   = ptr_r;
    sel_a_s  = {word_length{1'b0}};
    sel_b_s  = {word_length{1'b0}};
    for (int k = 0; k < num_req; k++) begin
      if (!found_s && bus.req[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
      cand_s = next_idx(cand_s);
    end
    for (int i = 0; i < num_req; i++) begin
      if (winner_s == idx_w'(i)) begin
        sel_a_s = bus.req_a[i*word_length +: word_length];
        sel_b_s = bus.req_b[i*word_length +: word_length];
      end else begin
        sel_a_s = sel_a_s;
      end
    end
  end

  // Job sequencing FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      ptr_r       <= {idx_w{1'b0}};
      owner_r     <= {idx_w{1'b0}};
      grant_r     <= {num_req{1'b0}};
      done_r      <= {num_req{1'b0}};
      result_r    <= {(2*word_length){1'b0}};
      busy_r      <= 1'b0;
      mul_start_r <= 1'b0;
      word0_r     <= {word_length{1'b0}};
      word1_r     <= {word_length{1'b0}};
    end else begin
      grant_r     <= {num_req{1'b0}};
      done_r      <= {num_req{1'b0}};
      mul_start_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // A busy multiplier holds every request off until it reports ready.
          if (bus.mul_ready && found_s) begin
            owner_r     <= winner_s;
            word0_r     <= sel_a_s;
            word1_r     <= sel_b_s;
            ptr_r       <= next_idx(winner_s);
            grant_r     <= onehot(winner_s);
            mul_start_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= ISSUE;
          end else begin
            busy_r      <= 1'b0;
          end
        end
        ISSUE: begin
          state_r <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!bus.mul_ready) begin
            state_r <= WAIT_DONE;
          end else begin
            state_r <= WAIT_ACK;
          end
        end
        WAIT_DONE: begin
          if (bus.mul_ready) begin
            result_r <= bus.mul_product;
            done_r   <= onehot(owner_r);
            state_r  <= DONE;
          end else begin
            state_r  <= WAIT_DONE;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant     = grant_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.busy      = busy_r;
  assign bus.mul_start = mul_start_r;
  assign bus.mul_word0 = word0_r;
  assign bus.mul_word1 = word1_r;
endmodule
